// File: rtl/alu_decode_issue_if.sv
// Bundle of signals between alu_decode_issue and the stages around it.
//   instr_valid/instr/instr_ready         : upstream instruction handshake
//   wb_en/wb_addr/wb_data                  : register-file write-back port
//   issue_valid/issue_ready                : downstream issue handshake
//   rs1_data/rs2_data/rd_addr              : issued operands and destination
//   add_en .. and_en                       : one-hot operation select
//   illegal_instr                          : one-cycle pulse for a rejected instruction
// master = the surrounding pipeline, slave = alu_decode_issue.
interface alu_decode_issue_if #(
   parameter int unsigned XLEN = 32
);
   logic            instr_valid;
   logic [31:0]     instr;
   logic            instr_ready;
   logic            wb_en;
   logic [4:0]      wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            issue_valid;
   logic            issue_ready;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_addr;
   logic            add_en, sub_en, sll_en, slt_en, sltu_en;
   logic            xor_en, srl_en, sra_en, or_en, and_en;
   logic            illegal_instr;

   modport master (
      output instr_valid, instr, wb_en, wb_addr, wb_data, issue_ready,
      input  instr_ready, issue_valid, rs1_data, rs2_data, rd_addr,
             add_en, sub_en, sll_en, slt_en, sltu_en,
             xor_en, srl_en, sra_en, or_en, and_en, illegal_instr
   );

   modport slave (
      input  instr_valid, instr, wb_en, wb_addr, wb_data, issue_ready,
      output instr_ready, issue_valid, rs1_data, rs2_data, rd_addr,
             add_en, sub_en, sll_en, slt_en, sltu_en,
             xor_en, srl_en, sra_en, or_en, and_en, illegal_instr
   );
endinterface

// File: rtl/alu_decode_issue.sv
// RV32 R-type ALU decode and issue stage with an integrated register file.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_decode_issue_if.slave (instruction, write-back and issue signals)
// Accepts one instruction per cycle when the issue register is empty or being
// drained, decodes it into a one-hot operation select, reads operands (with
// write-back bypass) and presents them one cycle later. Illegal instructions
// are dropped and flagged with a one-cycle illegal_instr pulse.
module alu_decode_issue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input logic             clk,
   input logic             rst,
   alu_decode_issue_if.slave bus
);
   localparam logic [6:0] OpcOp = 7'b0110011;

   logic [XLEN-1:0] rf [NREGS];

   logic            issue_valid_q;
   logic [9:0]      op_q;
   logic [XLEN-1:0] rs1_q, rs2_q;
   logic [4:0]      rd_q;
   logic            illegal_q;

   logic            instr_ready;
   logic            accept;
   logic [9:0]      op_sel;
   logic            legal;
   logic [4:0]      rs1_idx, rs2_idx;
   logic [XLEN-1:0] rs1_rd, rs2_rd;
   logic            wb_hit;

   assign instr_ready = !issue_valid_q || bus.issue_ready;
   assign accept      = bus.instr_valid && instr_ready;
   assign rs1_idx     = bus.instr[19:15];
   assign rs2_idx     = bus.instr[24:20];
   assign wb_hit      = bus.wb_en && (bus.wb_addr != 5'd0);

   // Bit order: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
   always_comb begin
      op_sel = '0;
      if (bus.instr[6:0] == OpcOp) begin
         unique case ({bus.instr[31:25], bus.instr[14:12]})
            10'b0000000_000: op_sel[0] = 1'b1;
            10'b0100000_000: op_sel[1] = 1'b1;
            10'b0000000_001: op_sel[2] = 1'b1;
            10'b0000000_010: op_sel[3] = 1'b1;
            10'b0000000_011: op_sel[4] = 1'b1;
            10'b0000000_100: op_sel[5] = 1'b1;
            10'b0000000_101: op_sel[6] = 1'b1;
            10'b0100000_101: op_sel[7] = 1'b1;
            10'b0000000_110: op_sel[8] = 1'b1;
            10'b0000000_111: op_sel[9] = 1'b1;
            default:         op_sel    = '0;
         endcase
      end
   end

   assign legal = |op_sel;

   // Operand read with same-cycle write-back bypass; x0 is hardwired to zero.
   always_comb begin
      rs1_rd = '0;
      rs2_rd = '0;
      if (rs1_idx != 5'd0) begin
         rs1_rd = (wb_hit && bus.wb_addr == rs1_idx) ? bus.wb_data : rf[rs1_idx];
      end
      if (rs2_idx != 5'd0) begin
         rs2_rd = (wb_hit && bus.wb_addr == rs2_idx) ? bus.wb_data : rf[rs2_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            rf[i] <= '0;
         end
         issue_valid_q <= 1'b0;
         op_q          <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         illegal_q     <= 1'b0;
      end else begin
         if (wb_hit) begin
            rf[bus.wb_addr] <= bus.wb_data;
         end
         illegal_q <= accept && !legal;
         if (accept && legal) begin
            issue_valid_q <= 1'b1;
            op_q          <= op_sel;
            rs1_q         <= rs1_rd;
            rs2_q         <= rs2_rd;
            rd_q          <= bus.instr[11:7];
         end else if (bus.issue_ready) begin
            // Drained with nothing new: clear the select so no *_en lingers.
            issue_valid_q <= 1'b0;
            op_q          <= '0;
         end
      end
   end

   assign bus.instr_ready   = instr_ready;
   assign bus.issue_valid   = issue_valid_q;
   assign bus.rs1_data      = rs1_q;
   assign bus.rs2_data      = rs2_q;
   assign bus.rd_addr       = rd_q;
   assign bus.illegal_instr = illegal_q;
   assign bus.add_en        = op_q[0];
   assign bus.sub_en        = op_q[1];
   assign bus.sll_en        = op_q[2];
   assign bus.slt_en        = op_q[3];
   assign bus.sltu_en       = op_q[4];
   assign bus.xor_en        = op_q[5];
   assign bus.srl_en        = op_q[6];
   assign bus.sra_en        = op_q[7];
   assign bus.or_en         = op_q[8];
   assign bus.and_en        = op_q[9];
endmodule

// File: tb/tb_alu_decode_issue.sv
module tb_alu_decode_issue;
   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_decode_issue_if #(.XLEN(XLEN)) bus ();

   alu_decode_issue #(.XLEN(XLEN), .NREGS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [31:0] m_rf [32];
   bit          m_valid;
   int          m_op;
   logic [31:0] m_rs1, m_rs2;
   logic [4:0]  m_rd;
   bit          m_ill;
   bit          m_data_known;

   // {funct7,funct3} per operation, in the order add..and.
   logic [9:0] op_table [10] = '{10'b0000000_000, 10'b0100000_000, 10'b0000000_001,
                                 10'b0000000_010, 10'b0000000_011, 10'b0000000_100,
                                 10'b0000000_101, 10'b0100000_101, 10'b0000000_110,
                                 10'b0000000_111};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int decode(input logic [31:0] ins);
      if (ins[6:0] != 7'b0110011) return -1;
      for (int i = 0; i < 10; i++) begin
         if ({ins[31:25], ins[14:12]} == op_table[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] rtype(input int op, input int rd, input int rs1, input int rs2);
      logic [9:0] f;
      f = op_table[op];
      return {f[9:3], rs2[4:0], rs1[4:0], f[2:0], rd[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
      return m_rf[idx];
   endfunction

   function automatic logic [9:0] en_vec();
      return {bus.and_en, bus.or_en, bus.sra_en, bus.srl_en, bus.xor_en,
              bus.sltu_en, bus.slt_en, bus.sll_en, bus.sub_en, bus.add_en};
   endfunction

   task automatic cycle(input string tag);
      bit m_ready;
      int op;
      #1;
      m_ready = !m_valid || bus.issue_ready;
      check({tag, ".instr_ready"}, 64'(bus.instr_ready), 64'(m_ready));
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
         m_valid = 0; m_op = -1; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ill = 0;
         m_data_known = 1;
      end else begin
         op    = decode(bus.instr);
         m_ill = bus.instr_valid && m_ready && (op < 0);
         if (bus.instr_valid && m_ready && op >= 0) begin
            m_valid = 1; m_op = op;
            m_rs1 = model_read(bus.instr[19:15]);
            m_rs2 = model_read(bus.instr[24:20]);
            m_rd  = bus.instr[11:7];
            m_data_known = 1;
         end else if (bus.issue_ready) begin
            m_valid = 0; m_op = -1; m_data_known = 0;
         end
         if (bus.wb_en && bus.wb_addr != 5'd0) m_rf[bus.wb_addr] = bus.wb_data;
      end
      #1;
      check({tag, ".issue_valid"}, 64'(bus.issue_valid), 64'(m_valid));
      check({tag, ".illegal"}, 64'(bus.illegal_instr), 64'(m_ill));
      check({tag, ".en"}, 64'(en_vec()), m_valid ? (64'd1 << m_op) : 64'd0);
      if (m_data_known) begin
         check({tag, ".rs1"}, 64'(bus.rs1_data), 64'(m_rs1));
         check({tag, ".rs2"}, 64'(bus.rs2_data), 64'(m_rs2));
         check({tag, ".rd"}, 64'(bus.rd_addr), 64'(m_rd));
      end
   endtask

   task automatic drive(input string tag, input bit v, input logic [31:0] ins, input bit wbe,
                        input logic [4:0] wba, input logic [31:0] wbd, input bit ird,
                        input bit r);
      rst             = r;
      bus.instr_valid = v;
      bus.instr       = ins;
      bus.wb_en       = wbe;
      bus.wb_addr     = wba;
      bus.wb_data     = wbd;
      bus.issue_ready = ird;
      cycle(tag);
   endtask

   initial begin
      logic [31:0] ins;
      int sel;
      m_valid = 0; m_op = -1; m_ill = 0; m_data_known = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 'x;

      // Reset, then idle cycle (instr_ready must be 1 straight after reset).
      drive("rst0", 0, 32'h0, 0, 5'd0, 32'h0, 1, 1);
      drive("rst1", 0, 32'h0, 0, 5'd0, 32'h0, 1, 1);
      drive("idle", 0, 32'h0, 0, 5'd0, 32'h0, 1, 0);

      // add x3,x1,x2 after writing x1=5, x2=6.
      drive("wb1", 0, 32'h0, 1, 5'd1, 32'd5, 1, 0);
      drive("wb2", 0, 32'h0, 1, 5'd2, 32'd6, 1, 0);
      drive("add", 1, 32'h002081B3, 0, 5'd0, 32'h0, 1, 0);
      check("add.rs1_const", 64'(bus.rs1_data), 64'd5);
      check("add.rs2_const", 64'(bus.rs2_data), 64'd6);
      check("add.rd_const", 64'(bus.rd_addr), 64'd3);
      check("add.en_const", 64'(en_vec()), 64'h1);

      // sub then sra back-to-back, consumed every cycle.
      drive("sub", 1, 32'h40208233, 0, 5'd0, 32'h0, 1, 0);
      check("sub.en_const", 64'(en_vec()), 64'h2);
      drive("sra", 1, 32'h4020D2B3, 0, 5'd0, 32'h0, 1, 0);
      check("sra.en_const", 64'(en_vec()), 64'h80);
      drive("drain", 0, 32'h0, 0, 5'd0, 32'h0, 1, 0);

      // addi is rejected.
      drive("addi", 1, 32'h00100093, 0, 5'd0, 32'h0, 1, 0);
      check("addi.pulse", 64'(bus.illegal_instr), 64'd1);
      drive("addi_after", 0, 32'h0, 0, 5'd0, 32'h0, 1, 0);
      check("addi.pulse_end", 64'(bus.illegal_instr), 64'd0);

      // Same-cycle write-back bypass on rs1.
      drive("byp", 1, 32'h002081B3, 1, 5'd1, 32'hF0000002, 1, 0);
      check("byp.rs1_const", 64'(bus.rs1_data), 64'hF0000002);

      // Stall three cycles while x1 is rewritten and new work is offered.
      drive("stall_acc", 1, 32'h002081B3, 0, 5'd0, 32'h0, 0, 0);
      drive("stall1", 1, 32'h40208233, 1, 5'd1, 32'hAA, 0, 0);
      drive("stall2", 1, 32'h40208233, 0, 5'd0, 32'h0, 0, 0);
      drive("stall3", 1, 32'h40208233, 0, 5'd0, 32'h0, 0, 0);
      check("stall.rs1_held", 64'(bus.rs1_data), 64'hF0000002);
      drive("consume", 0, 32'h0, 0, 5'd0, 32'h0, 1, 0);

      // Reset during a stall; then x1 reads as zero.
      drive("stall_b", 1, 32'h002081B3, 0, 5'd0, 32'h0, 0, 0);
      drive("rst_stall", 1, 32'h002081B3, 1, 5'd1, 32'h77, 0, 1);
      drive("post_rst", 1, 32'h002081B3, 0, 5'd0, 32'h0, 1, 0);
      check("post_rst.rs1_const", 64'(bus.rs1_data), 64'd0);
      drive("post_rst2", 0, 32'h0, 0, 5'd0, 32'h0, 1, 0);

      // Randomized traffic on a small register window to provoke bypass hits.
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 7)       ins = rtype(int'($urandom_range(0, 9)), int'($urandom_range(0, 7)),
                                        int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         else if (sel == 7) ins = $urandom;
         else if (sel == 8) ins = {7'($urandom), 8'($urandom), 10'($urandom), 7'b0110011};
         else               ins = {25'($urandom), 7'b0010011};
         drive("rand", $urandom_range(0, 3) != 0, ins, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 99) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
